// File: rtl/seq1111_pkg.sv
// rtl/seq1111_pkg.sv - state encoding and framing constants shared by the 1111 transmitter and detector
//
// Purpose : single source of truth for the line-state codes reported on status
//           and for the preamble / stuffing run lengths.
// Ports   : none (package).
package seq1111_pkg;

    // Number of 1-bits in the frame preamble; the detector triggers on this run.
    localparam int PRE_LEN   = 4;
    // A data run of this many 1s forces a stuffed 0 before the next bit.
    localparam int STUFF_RUN = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_DATA  = 3'd2,
        ST_STUFF = 3'd3,
        ST_GAP   = 3'd4,
        ST_PAR   = 3'd5
    } state_t;

endpackage

// File: rtl/seq1111_runcnt.sv
// rtl/seq1111_runcnt.sv - consecutive-ones counter that flags when a stuff bit is due
//
// Purpose : counts consecutive 1s among transmitted data bits.
// Ports   : clk      - rising-edge clock
//           rst      - asynchronous active-low reset
//           en       - a data bit is being put on the line this edge
//           data_bit - value of that data bit
//           clear    - restart the run (new frame or stuffed 0)
//           hit      - run has reached STUFF_RUN
module seq1111_runcnt
    import seq1111_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic data_bit,
    input  logic clear,
    output logic hit
);

    logic [1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            if (!data_bit) begin
                cnt <= '0;
            end else if (cnt != 2'd3) begin
                // Saturate: a trailing run at the end of a frame may exceed
                // the stuffing threshold without a stuff bit being inserted.
                cnt <= cnt + 2'd1;
            end
        end
    end

    assign hit = (cnt == 2'(STUFF_RUN));

endmodule

// File: rtl/seqgen1111_tx.sv
// rtl/seqgen1111_tx.sv - serial frame transmitter: 1111 preamble, stuffed LSB-first data, 0 gap
//
// Purpose : accepts a W-bit word on valid/ready and serialises it on x.
//           Optional macro PARITY_EN appends an even-parity bit before the gap.
// Ports   : clk     - rising-edge clock
//           rst     - asynchronous active-low reset
//           data_in - word to send, sampled on valid && ready
//           valid   - data_in is valid
//           ready   - a word can be accepted this cycle (IDLE or GAP)
//           x       - registered serial line
//           busy    - frame body (PRE/DATA/STUFF/PAR) on the line
//           status  - current state code
module seqgen1111_tx #(
    parameter int W       = 8,
    parameter int PRE_LEN = seq1111_pkg::PRE_LEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_in,
    input  logic         valid,
    output logic         ready,
    output logic         x,
    output logic         busy,
    output logic [2:0]   status
);

    import seq1111_pkg::*;

    localparam int CMAX = (W > PRE_LEN) ? W : PRE_LEN;
    localparam int CW   = $clog2(CMAX + 1);

    state_t        state;
    logic [W-1:0]  shreg;
    logic [CW-1:0] cnt;       // preamble bits in PRE, data bits sent otherwise
    logic          hit;
    logic          accept;
    logic          load_bit;  // next data bit goes onto x this edge
    logic          go_stuff;
    logic          last_bit;
    logic          stuff_ok;
`ifdef PARITY_EN
    logic          par;
`endif

    assign ready    = rst && (state == ST_IDLE || state == ST_GAP);
    assign accept   = valid && ready;
    assign last_bit = (cnt == CW'(W));
    assign status   = state;

`ifdef PARITY_EN
    assign busy     = state inside {ST_PRE, ST_DATA, ST_STUFF, ST_PAR};
    // The parity bit still follows the last data bit, so a run there needs a stuff.
    assign stuff_ok = 1'b1;
`else
    assign busy     = state inside {ST_PRE, ST_DATA, ST_STUFF};
    // After the final data bit the gap 0 breaks the run by itself.
    assign stuff_ok = !last_bit;
`endif

    always_comb begin
        go_stuff = 1'b0;
        load_bit = 1'b0;
        case (state)
            ST_PRE:   load_bit = (cnt == CW'(PRE_LEN));
            ST_DATA: begin
                go_stuff = hit && stuff_ok;
                load_bit = !go_stuff && !last_bit;
            end
            ST_STUFF: load_bit = !last_bit;
            default:  ;
        endcase
    end

    seq1111_runcnt u_runcnt (
        .clk      (clk),
        .rst      (rst),
        .en       (load_bit),
        .data_bit (shreg[0]),
        .clear    (accept || go_stuff),
        .hit      (hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            x     <= 1'b0;
            shreg <= '0;
            cnt   <= '0;
`ifdef PARITY_EN
            par   <= 1'b0;
`endif
        end else if (accept) begin
            state <= ST_PRE;
            x     <= 1'b1;
            shreg <= data_in;
            cnt   <= CW'(1);
`ifdef PARITY_EN
            par   <= 1'b0;
`endif
        end else if (load_bit) begin
            state <= ST_DATA;
            x     <= shreg[0];
            shreg <= shreg >> 1;
            cnt   <= (state == ST_PRE) ? CW'(1) : cnt + CW'(1);
`ifdef PARITY_EN
            par   <= par ^ shreg[0];
`endif
        end else begin
            case (state)
                ST_PRE: begin
                    x   <= 1'b1;
                    cnt <= cnt + CW'(1);
                end
                ST_DATA: begin
                    if (go_stuff) begin
                        state <= ST_STUFF;
                        x     <= 1'b0;
                    end else begin
`ifdef PARITY_EN
                        state <= ST_PAR;
                        x     <= par;
`else
                        state <= ST_GAP;
                        x     <= 1'b0;
`endif
                    end
                end
                ST_STUFF: begin
                    // Only reached when all data bits are out (stuff before parity).
`ifdef PARITY_EN
                    state <= ST_PAR;
                    x     <= par;
`else
                    state <= ST_GAP;
                    x     <= 1'b0;
`endif
                end
`ifdef PARITY_EN
                ST_PAR: begin
                    state <= ST_GAP;
                    x     <= 1'b0;
                end
`endif
                default: begin
                    // IDLE, GAP without a new word, and any unused code.
                    state <= ST_IDLE;
                    x     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seqgen1111_tx.sv
// tb/tb_seqgen1111_tx.sv - self-checking bench for seqgen1111_tx
module tb_seqgen1111_tx;

    localparam int W = 8;
    localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_DATA = 3'd2,
                           S_STUFF = 3'd3, S_GAP = 3'd4, S_PAR = 3'd5;
`ifdef PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         ready;
    logic         x;
    logic         busy;
    logic [2:0]   status;

    seqgen1111_tx #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .x       (x),
        .busy    (busy),
        .status  (status)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       b;
        logic [2:0] st;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        e;
    logic        exp_busy;
    logic        exp_ready;
    int          n_checks = 0;
    int          n_err = 0;
    int          acc_cnt = 0;
    int          fires = 0;
    int          busy_cyc = 0;
    logic [3:0]  hist = '0;
    logic        det_prev = 1'b0;
    logic [31:0] m_bits;
    logic [95:0] m_sts;
    int          m_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_push(input logic b, input logic [2:0] s);
        m_bits = {m_bits[30:0], b};
        m_sts  = {m_sts[92:0], s};
        m_len++;
    endfunction

    // Frame built straight from the line rules: preamble, LSB-first data with a
    // 0 after every third consecutive 1 that is followed by another bit, parity, gap.
    function automatic void model_frame(input logic [W-1:0] d);
        int run = 0;
        m_bits = '0;
        m_sts  = '0;
        m_len  = 0;
        for (int i = 0; i < 4; i++) m_push(1'b1, S_PRE);
        for (int i = 0; i < W; i++) begin
            m_push(d[i], S_DATA);
            run = d[i] ? run + 1 : 0;
            if (run == 3 && (i < W - 1 || PAR_EN)) begin
                m_push(1'b0, S_STUFF);
                run = 0;
            end
        end
        if (PAR_EN) m_push(^d, S_PAR);
        m_push(1'b0, S_GAP);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_x", 32'(x), 32'd0);
            chk("rst_status", 32'(status), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ready", 32'(ready), 32'd0);
            exp_q.delete();
            hist = '0;
            det_prev = 1'b0;
        end else begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '0;
            exp_busy  = (e.st == S_PRE) || (e.st == S_DATA) || (e.st == S_STUFF) || (e.st == S_PAR);
            exp_ready = (e.st == S_IDLE) || (e.st == S_GAP);
            chk("x", 32'(x), 32'(e.b));
            chk("status", 32'(status), 32'(e.st));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("ready", 32'(ready), 32'(exp_ready));
            hist = {hist[2:0], x};
            if (hist == 4'hF && !det_prev) fires++;
            det_prev = (hist == 4'hF);
            if (busy) busy_cyc++;
            if (valid && exp_ready) begin
                model_frame(data_in);
                for (int k = m_len - 1; k >= 0; k--)
                    exp_q.push_back(ent_t'({m_bits[k], m_sts[3*k +: 3]}));
                acc_cnt++;
            end
        end
    end

    task automatic wait_acc(input int target);
        int t = 0;
        while (acc_cnt < target && t < 60) begin
            @(negedge clk); #1;
            t++;
        end
        chk("accept_timeout", 32'(acc_cnt >= target), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk); #1;
            t++;
        end
        chk("idle_timeout", 32'(exp_q.size() == 0), 32'd1);
    endtask

    task automatic send(input logic [W-1:0] d);
        int start;
        @(posedge clk); #1;
        start   = acc_cnt;
        valid   = 1'b1;
        data_in = d;
        wait_acc(start + 1);
        valid   = 1'b0;
        data_in = ~d;
        wait_idle();
    endtask

    initial begin
        int start;

`ifdef PARITY_EN
        model_frame(8'hFF);
        chk("pin_ff_len", 32'(m_len), 32'd16);
        chk("pin_ff_bits", m_bits, 32'b1111111011101100);
        model_frame(8'h01);
        chk("pin_01_len", 32'(m_len), 32'd14);
        chk("pin_01_bits", m_bits, 32'b11111000000010);
`else
        model_frame(8'h00);
        chk("pin_00_len", 32'(m_len), 32'd13);
        chk("pin_00_bits", m_bits, 32'b1111000000000);
        model_frame(8'hFF);
        chk("pin_ff_len", 32'(m_len), 32'd15);
        chk("pin_ff_bits", m_bits, 32'b111111101110110);
        model_frame(8'h07);
        chk("pin_07_len", 32'(m_len), 32'd14);
        chk("pin_07_bits", m_bits, 32'b11111110000000);
        model_frame(8'hE0);
        chk("pin_e0_len", 32'(m_len), 32'd13);
        chk("pin_e0_bits", m_bits, 32'b1111000001110);
`endif

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        busy_cyc = 0;
        send(8'h00);
        chk("busy_cycles_00", 32'(busy_cyc), 32'(12 + int'(PAR_EN)));

        busy_cyc = 0;
        send(8'hFF);
        chk("busy_cycles_ff", 32'(busy_cyc), 32'(14 + int'(PAR_EN)));

        send(8'h07);
        send(8'hE0);
        send(8'h01);
        send(8'hB6);

        // Back-to-back: valid held, second word taken in the first frame's GAP.
        fires = 0;
        @(posedge clk); #1;
        start   = acc_cnt;
        valid   = 1'b1;
        data_in = 8'hFF;
        wait_acc(start + 1);
        data_in = 8'h00;
        wait_acc(start + 2);
        valid   = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("detector_fires", 32'(fires), 32'd2);

        // Asynchronous reset in the middle of the data field.
        @(posedge clk); #1;
        start   = acc_cnt;
        valid   = 1'b1;
        data_in = 8'hA5;
        wait_acc(start + 1);
        valid   = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_x", 32'(x), 32'd0);
        chk("async_rst_status", 32'(status), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("post_rst_ready", 32'(ready), 32'd1);
        chk("post_rst_status", 32'(status), 32'd0);
        send(8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
